// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
// Inserts a single bubble when a load in EX feeds the instruction in ID,
// kills the ID instruction on a taken branch, and counts stall/flush events.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             Valid_ID,
    input  logic [4:0]       RS1Addr_ID,
    input  logic [4:0]       RS2Addr_ID,
    input  logic [4:0]       RDAddr_ID,
    input  logic [XLEN-1:0]  RS1Data_ID,
    input  logic [XLEN-1:0]  RS2Data_ID,
    input  logic [XLEN-1:0]  Imm_ID,
    input  logic [9:0]       Funct_ID,
    input  logic [1:0]       ALUOp_ID,
    input  logic             ALUSrc_ID,
    input  logic             RegWrite_ID,
    input  logic             MemtoReg_ID,
    input  logic             MemRead_ID,
    input  logic             MemWrite_ID,
    input  logic             Flush_i,
    output logic             Valid_EX,
    output logic [4:0]       RS1Addr_EX,
    output logic [4:0]       RS2Addr_EX,
    output logic [4:0]       RDAddr_EX,
    output logic [XLEN-1:0]  RS1Data_EX,
    output logic [XLEN-1:0]  RS2Data_EX,
    output logic [XLEN-1:0]  Imm_EX,
    output logic [9:0]       Funct_EX,
    output logic [1:0]       ALUOp_EX,
    output logic             ALUSrc_EX,
    output logic             RegWrite_EX,
    output logic             MemtoReg_EX,
    output logic             MemRead_EX,
    output logic             MemWrite_EX,
    output logic             Stall_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o
);

    // Fields that must be cleared on a bubble so it can never match or write.
    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    // Payload fields that are don't-care inside a bubble and simply hold.
    typedef struct packed {
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [9:0]      funct;
    } data_t;

    ctrl_t ctrl_d, ctrl_q;
    data_t data_d, data_q;
    logic  hazard;
    logic  bubble;
    logic  [CNT_W-1:0] stall_cnt, flush_cnt;

    assign ctrl_d = '{valid: 1'b1, rs1: RS1Addr_ID, rs2: RS2Addr_ID, rd: RDAddr_ID,
                      alu_op: ALUOp_ID, alu_src: ALUSrc_ID, reg_write: RegWrite_ID,
                      mem_to_reg: MemtoReg_ID, mem_read: MemRead_ID, mem_write: MemWrite_ID};
    assign data_d = '{rs1_data: RS1Data_ID, rs2_data: RS2Data_ID, imm: Imm_ID, funct: Funct_ID};

    // Load-use detection; both source fields are compared regardless of opcode.
    always_comb begin
        hazard = ctrl_q.mem_read & ctrl_q.valid & Valid_ID & (ctrl_q.rd != 5'd0) &
                 ((ctrl_q.rd == RS1Addr_ID) | (ctrl_q.rd == RS2Addr_ID));
        bubble = hazard | Flush_i | ~Valid_ID;
    end

    // A flush kills the instruction anyway, so it suppresses the stall.
    assign Stall_o = hazard & ~Flush_i;

    // Control/address register: load on advance, clear on bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)      ctrl_q <= '0;
        else if (bubble) ctrl_q <= '0;
        else             ctrl_q <= ctrl_d;
    end

    // Payload register: load on advance, hold on bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)       data_q <= '0;
        else if (!bubble) data_q <= data_d;
    end

    // Free-running debug event counters, wrapping on overflow.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (Stall_o)             stall_cnt <= stall_cnt + CNT_W'(1);
            if (Flush_i && Valid_ID) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign Valid_EX    = ctrl_q.valid;
    assign RS1Addr_EX  = ctrl_q.rs1;
    assign RS2Addr_EX  = ctrl_q.rs2;
    assign RDAddr_EX   = ctrl_q.rd;
    assign ALUOp_EX    = ctrl_q.alu_op;
    assign ALUSrc_EX   = ctrl_q.alu_src;
    assign RegWrite_EX = ctrl_q.reg_write;
    assign MemtoReg_EX = ctrl_q.mem_to_reg;
    assign MemRead_EX  = ctrl_q.mem_read;
    assign MemWrite_EX = ctrl_q.mem_write;
    assign RS1Data_EX  = data_q.rs1_data;
    assign RS2Data_EX  = data_q.rs2_data;
    assign Imm_EX      = data_q.imm;
    assign Funct_EX    = data_q.funct;
    assign StallCnt_o  = stall_cnt;
    assign FlushCnt_o  = flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of the ID/EX register and hazard logic.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             Valid_ID = 1'b0;
    logic [4:0]       RS1Addr_ID = '0, RS2Addr_ID = '0, RDAddr_ID = '0;
    logic [XLEN-1:0]  RS1Data_ID = '0, RS2Data_ID = '0, Imm_ID = '0;
    logic [9:0]       Funct_ID = '0;
    logic [1:0]       ALUOp_ID = '0;
    logic             ALUSrc_ID = 1'b0, RegWrite_ID = 1'b0, MemtoReg_ID = 1'b0;
    logic             MemRead_ID = 1'b0, MemWrite_ID = 1'b0, Flush_i = 1'b0;
    logic             Valid_EX;
    logic [4:0]       RS1Addr_EX, RS2Addr_EX, RDAddr_EX;
    logic [XLEN-1:0]  RS1Data_EX, RS2Data_EX, Imm_EX;
    logic [9:0]       Funct_EX;
    logic [1:0]       ALUOp_EX;
    logic             ALUSrc_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX;
    logic             Stall_o;
    logic [CNT_W-1:0] StallCnt_o, FlushCnt_o;

    int errors = 0;
    int checks = 0;
    logic [CNT_W-1:0] exp_stall = '0;
    logic [CNT_W-1:0] exp_flush = '0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .Valid_ID(Valid_ID),
        .RS1Addr_ID(RS1Addr_ID), .RS2Addr_ID(RS2Addr_ID), .RDAddr_ID(RDAddr_ID),
        .RS1Data_ID(RS1Data_ID), .RS2Data_ID(RS2Data_ID), .Imm_ID(Imm_ID),
        .Funct_ID(Funct_ID), .ALUOp_ID(ALUOp_ID), .ALUSrc_ID(ALUSrc_ID),
        .RegWrite_ID(RegWrite_ID), .MemtoReg_ID(MemtoReg_ID), .MemRead_ID(MemRead_ID),
        .MemWrite_ID(MemWrite_ID), .Flush_i(Flush_i),
        .Valid_EX(Valid_EX), .RS1Addr_EX(RS1Addr_EX), .RS2Addr_EX(RS2Addr_EX),
        .RDAddr_EX(RDAddr_EX), .RS1Data_EX(RS1Data_EX), .RS2Data_EX(RS2Data_EX),
        .Imm_EX(Imm_EX), .Funct_EX(Funct_EX), .ALUOp_EX(ALUOp_EX), .ALUSrc_EX(ALUSrc_EX),
        .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .MemRead_EX(MemRead_EX),
        .MemWrite_EX(MemWrite_EX), .Stall_o(Stall_o), .StallCnt_o(StallCnt_o),
        .FlushCnt_o(FlushCnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded, summary not reached");
        $fatal(1, "timeout");
    end

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic put_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] imm, input logic [9:0] fn, input logic [1:0] op,
                             input logic src, input logic rw, input logic m2r,
                             input logic mr, input logic mw);
        Valid_ID = v; RS1Addr_ID = rs1; RS2Addr_ID = rs2; RDAddr_ID = rd;
        RS1Data_ID = d1; RS2Data_ID = d2; Imm_ID = imm; Funct_ID = fn; ALUOp_ID = op;
        ALUSrc_ID = src; RegWrite_ID = rw; MemtoReg_ID = m2r; MemRead_ID = mr; MemWrite_ID = mw;
        #1;
    endtask

    task automatic put_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        put_instr(1'b1, rs1, rs2, rd, 32'h100 + 32'(rs1), 32'h200 + 32'(rs2), 32'h0,
                  10'h000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic put_lw(input logic [4:0] rd, input logic [4:0] rs1);
        put_instr(1'b1, rs1, 5'd0, rd, 32'h300 + 32'(rs1), 32'h0, 32'h4,
                  10'h002, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        logic [4:0]  r1, r2, rd;
        logic [31:0] d1, d2, im;
        logic [9:0]  fn;
        logic [1:0]  op;
        logic [4:0]  cb;
        r1 = 5'($urandom); r2 = 5'($urandom); rd = 5'($urandom);
        d1 = $urandom; d2 = $urandom; im = $urandom; fn = 10'($urandom);
        op = 2'($urandom); cb = 5'($urandom);
        rst_i = 1'b0;
        put_instr(1'b1, r1, r2, rd, d1, d2, im, fn, op, cb[0], cb[1], cb[2], cb[3], cb[4]);
        repeat (3) step();
        checks++;
        if ({Valid_EX, RS1Addr_EX, RS2Addr_EX, RDAddr_EX, RS1Data_EX, RS2Data_EX, Imm_EX, Funct_EX,
             ALUOp_EX, ALUSrc_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX} !== '0) begin
            errors++; $display("FAIL reset_ex_zero: got valid=%b rd=%0d d1=%h, want all zero", Valid_EX, RDAddr_EX, RS1Data_EX);
        end
        checks++;
        if (Stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall_o); end
        checks++;
        if ({StallCnt_o, FlushCnt_o} !== '0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", StallCnt_o, FlushCnt_o);
        end
        // Release mid-cycle; the following edge captures the ID values.
        rst_i = 1'b1;
        step();
        checks++;
        if ({Valid_EX, RS1Addr_EX, RS2Addr_EX, RDAddr_EX, RS1Data_EX, RS2Data_EX, Imm_EX, Funct_EX,
             ALUOp_EX, ALUSrc_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX} !==
            {1'b1, r1, r2, rd, d1, d2, im, fn, op, cb[0], cb[1], cb[2], cb[3], cb[4]}) begin
            errors++; $display("FAIL reset_release_capture: got rd=%0d d1=%h imm=%h want rd=%0d d1=%h imm=%h",
                               RDAddr_EX, RS1Data_EX, Imm_EX, rd, d1, im);
        end
    endtask

    task automatic test_plain_advance();
        put_add(5'd3, 5'd1, 5'd2);
        step();
        checks++;
        if ({Valid_EX, RDAddr_EX, RegWrite_EX, RS1Data_EX, RS2Data_EX, ALUOp_EX} !==
            {1'b1, 5'd3, 1'b1, 32'h101, 32'h202, 2'b10}) begin
            errors++; $display("FAIL plain_advance: got v=%b rd=%0d rw=%b d1=%h d2=%h want 1/3/1/101/202",
                               Valid_EX, RDAddr_EX, RegWrite_EX, RS1Data_EX, RS2Data_EX);
        end
    endtask

    task automatic test_load_use();
        put_lw(5'd5, 5'd1);
        step();
        put_add(5'd6, 5'd5, 5'd7);
        checks++;
        if (Stall_o !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b want 1", Stall_o); end
        step();
        exp_stall = exp_stall + 1'b1;
        checks++;
        if ({Valid_EX, RegWrite_EX, RDAddr_EX, MemRead_EX, RS1Addr_EX, RS2Addr_EX} !== '0) begin
            errors++; $display("FAIL load_use_bubble: got v=%b rw=%b rd=%0d mr=%b want all 0",
                               Valid_EX, RegWrite_EX, RDAddr_EX, MemRead_EX);
        end
        checks++;
        if (StallCnt_o !== exp_stall) begin errors++; $display("FAIL load_use_cnt: got %0d want %0d", StallCnt_o, exp_stall); end
        checks++;
        if (Stall_o !== 1'b0) begin errors++; $display("FAIL load_use_release: got %b want 0", Stall_o); end
        step();
        checks++;
        if ({Valid_EX, RDAddr_EX, RS1Data_EX} !== {1'b1, 5'd6, 32'h105}) begin
            errors++; $display("FAIL load_use_advance: got v=%b rd=%0d d1=%h want 1/6/105", Valid_EX, RDAddr_EX, RS1Data_EX);
        end
    endtask

    task automatic test_x0_load();
        put_lw(5'd0, 5'd1);
        step();
        put_add(5'd1, 5'd0, 5'd0);
        checks++;
        if (Stall_o !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", Stall_o); end
        step();
        checks++;
        if ({Valid_EX, RDAddr_EX} !== {1'b1, 5'd1}) begin
            errors++; $display("FAIL x0_advance: got v=%b rd=%0d want 1/1", Valid_EX, RDAddr_EX);
        end
    endtask

    task automatic test_flush_hazard();
        put_lw(5'd5, 5'd1);
        step();
        put_add(5'd6, 5'd5, 5'd7);
        Flush_i = 1'b1;
        #1;
        checks++;
        if (Stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", Stall_o); end
        step();
        Flush_i = 1'b0;
        exp_flush = exp_flush + 1'b1;
        checks++;
        if ({Valid_EX, RDAddr_EX, RegWrite_EX} !== '0) begin
            errors++; $display("FAIL flush_bubble: got v=%b rd=%0d rw=%b want 0", Valid_EX, RDAddr_EX, RegWrite_EX);
        end
        checks++;
        if ({FlushCnt_o, StallCnt_o} !== {exp_flush, exp_stall}) begin
            errors++; $display("FAIL flush_cnt: got flush=%0d stall=%0d want %0d/%0d", FlushCnt_o, StallCnt_o, exp_flush, exp_stall);
        end
    endtask

    task automatic test_invalid_id();
        put_add(5'd9, 5'd1, 5'd2);
        step();
        // Invalid ID: bubble, payload holds, no hazard even on a matching field.
        put_instr(1'b0, 5'd9, 5'd9, 5'd4, 32'hdead, 32'hbeef, 32'h1, 10'h3ff, 2'b11,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        checks++;
        if ({Valid_EX, RDAddr_EX, MemWrite_EX, RS1Data_EX} !== {1'b0, 5'd0, 1'b0, 32'h101}) begin
            errors++; $display("FAIL invalid_id_bubble: got v=%b rd=%0d mw=%b d1=%h want 0/0/0/101",
                               Valid_EX, RDAddr_EX, MemWrite_EX, RS1Data_EX);
        end
    endtask

    task automatic test_back_to_back();
        put_lw(5'd5, 5'd1);
        step();
        put_lw(5'd6, 5'd2);
        checks++;
        if (Stall_o !== 1'b0) begin errors++; $display("FAIL b2b_load_load: got %b want 0", Stall_o); end
        step();
        put_add(5'd7, 5'd3, 5'd6);
        checks++;
        if (Stall_o !== 1'b1) begin errors++; $display("FAIL b2b_use_stall: got %b want 1", Stall_o); end
        step();
        exp_stall = exp_stall + 1'b1;
        checks++;
        if (Stall_o !== 1'b0) begin errors++; $display("FAIL b2b_single_stall: got %b want 0", Stall_o); end
        step();
        checks++;
        if ({Valid_EX, RDAddr_EX, StallCnt_o} !== {1'b1, 5'd7, exp_stall}) begin
            errors++; $display("FAIL b2b_advance: got v=%b rd=%0d cnt=%0d want 1/7/%0d", Valid_EX, RDAddr_EX, StallCnt_o, exp_stall);
        end
    endtask

    task automatic test_reset_mid_stall_and_wrap();
        put_lw(5'd5, 5'd1);
        step();
        put_add(5'd6, 5'd5, 5'd7);
        rst_i = 1'b0;
        #1;
        checks++;
        if ({Valid_EX, MemRead_EX, Stall_o, StallCnt_o, FlushCnt_o} !== '0) begin
            errors++; $display("FAIL mid_stall_reset: got v=%b mr=%b stall=%b cnt=%0d/%0d want all 0",
                               Valid_EX, MemRead_EX, Stall_o, StallCnt_o, FlushCnt_o);
        end
        #1 rst_i = 1'b1;
        step();
        checks++;
        if ({Valid_EX, RDAddr_EX, StallCnt_o} !== {1'b1, 5'd6, 4'd0}) begin
            errors++; $display("FAIL mid_stall_release: got v=%b rd=%0d cnt=%0d want 1/6/0", Valid_EX, RDAddr_EX, StallCnt_o);
        end
        for (int i = 0; i < 17; i++) begin
            put_lw(5'd5, 5'd1);
            step();
            put_add(5'd6, 5'd5, 5'd7);
            step();
        end
        checks++;
        if (StallCnt_o !== 4'd1) begin errors++; $display("FAIL cnt_wrap: got %0d want 1", StallCnt_o); end
    endtask

    initial begin
        test_reset();
        test_plain_advance();
        test_load_use();
        test_x0_load();
        test_flush_hazard();
        test_invalid_id();
        test_back_to_back();
        test_reset_mid_stall_and_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the five-stage RISC-V core. It captures decoded operands and control from ID and presents them to EX, the forwarding unit and the ALU. It stalls the front end for one cycle and injects a bubble when an EX-stage load feeds the instruction in ID. It also kills the ID instruction on a taken branch and keeps free-running stall/flush event counters for debug.

## Interface
Parameters:
- XLEN, 32, data/immediate width
- CNT_W, 16, width of each event counter

Ports:
- clk_i  in  1  core clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- Valid_ID  in  1  ID holds a real instruction
- RS1Addr_ID, RS2Addr_ID, RDAddr_ID  in  5 each  register specifiers from decode
- RS1Data_ID, RS2Data_ID  in  XLEN each  register-file read data
- Imm_ID  in  XLEN  sign-extended immediate
- Funct_ID  in  10  {funct7, funct3}
- ALUOp_ID  in  2  ALU control class
- ALUSrc_ID, RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID  in  1 each  control bits
- Flush_i  in  1  taken branch resolved in ID; kill the ID instruction
- Valid_EX, RS1Addr_EX, RS2Addr_EX, RDAddr_EX, RS1Data_EX, RS2Data_EX, Imm_EX, Funct_EX, ALUOp_EX, ALUSrc_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX  out  same widths as ID inputs  registered EX-stage copies
- Stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- StallCnt_o, FlushCnt_o  out  CNT_W each  event counters

## Operation
- Hazard (combinational) = MemRead_EX & Valid_EX & Valid_ID & (RDAddr_EX != 0) & (RDAddr_EX == RS1Addr_ID | RDAddr_EX == RS2Addr_ID). Both source fields are compared for every opcode, which is intentionally conservative.
- Stall_o = Hazard & ~Flush_i.
- Bubble = Hazard | Flush_i | ~Valid_ID.
- Each rising edge:
  - Bubble = 0: every EX output register loads its ID counterpart, and Valid_EX becomes 1.
  - Bubble = 1: Valid_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX and ALUOp_EX become 0. RDAddr_EX, RS1Addr_EX and RS2Addr_EX become 0, so a bubble can never match in forwarding or hazard logic. Data, Imm and Funct registers hold their previous values (don't-care).
- This block does not hold IF/ID. The upstream stage keeps the stalled instruction in ID, and it is re-evaluated the next cycle. At that point MemRead_EX is 0 (bubble), so Stall_o deasserts and the instruction advances.
- Flush and hazard in the same cycle: the flush wins. Stall_o = 0, a bubble is inserted, and only FlushCnt increments.
- StallCnt_o increments when Stall_o = 1. FlushCnt_o increments when Flush_i & Valid_ID. Both counters wrap from 2^CNT_W−1 to 0 and never saturate.

## Timing
- Latency: exactly one cycle from ID inputs to EX outputs, with no combinational path from ID data to EX outputs.
- Stall_o depends combinationally on current ID inputs and registered EX state. It must settle within the same cycle.
- Load-use penalty: exactly one bubble per dependent load. A back-to-back load→load→use sequence stalls once, only on the use.
- Reset (rst_i low, asynchronous): all EX outputs go to 0, including Valid_EX and all control bits. StallCnt_o and FlushCnt_o go to 0. Stall_o evaluates to 0, because Valid_EX = 0.
- Reset asserted mid-stall: the pending bubble and all state are discarded. After release, the first edge captures the ID inputs normally.
- Reset release is sampled synchronously by downstream logic. No output changes on the deasserting edge itself.

## Test plan
- Reset: drive rst_i low for 3 cycles with random ID inputs → all EX outputs are 0, Stall_o = 0, both counters are 0. Release → the next edge captures the ID values.
- Plain advance: `add x3,x1,x2` → Valid_EX = 1, RDAddr_EX = 3, RegWrite_EX = 1, RS1Data_EX = RS1Data_ID one cycle later.
- Load-use: `lw x5` in EX, then ID `add x6,x5,x7` → Stall_o = 1 for one cycle, EX gets a bubble (RegWrite_EX = 0, RDAddr_EX = 0), StallCnt = 1. Next cycle the add enters EX with Stall_o = 0.
- x0 load: `lw x0` in EX, ID reads x0 → Stall_o = 0, no bubble.
- Flush with hazard: the load-use condition and Flush_i = 1 in the same cycle → Stall_o = 0, bubble inserted, FlushCnt = 1, StallCnt unchanged.
- Counter wrap: with CNT_W = 4, force 17 load-use stalls → StallCnt_o = 1.
